sram_fifo_arb: RTL and testbench

SRAM_FIFO_ARB -- requirements
Module: sram_fifo_arb

---
 rtl/sram_fifo_arb.sv | 240 ++++++++++++++++++++++++
 tb/tb_sram_fifo_arb.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_fifo_arb.sv
// N_FIFO packet-capable FIFOs sharing one asynchronous SRAM.
// A round-robin arbiter serves 2*N_FIFO sources through a 5-cycle access FSM.

module sram_fifo_arb_ptr #(
    parameter int FIFO_AW = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_done,
    input  logic               rd_done,
    input  logic               mark,
    input  logic               commit,
    input  logic               rollback,
    output logic [FIFO_AW-1:0] wr_addr,
    output logic [FIFO_AW-1:0] rd_addr,
    output logic               empty,
    output logic               full,
    output logic [FIFO_AW:0]   level
);
    localparam int PW = FIFO_AW + 1;

    // One extra wrap bit per pointer separates full from empty.
    logic [PW-1:0] wr_ptr, rd_ptr, commit_ptr, mark_ptr;
    logic [PW-1:0] wr_n, rd_n, commit_n, mark_n;
    logic          pkt_open, open_n;

    always_comb begin
        wr_n     = wr_ptr + PW'(wr_done);
        rd_n     = rd_ptr + PW'(rd_done);
        commit_n = pkt_open ? commit_ptr : wr_n;
        mark_n   = mark_ptr;
        open_n   = pkt_open;
        // The write finishing this cycle is already folded into wr_n.
        if (rollback) begin
            if (pkt_open) begin
                wr_n     = mark_ptr;
                commit_n = commit_ptr;
                open_n   = 1'b0;
            end
        end else if (commit) begin
            if (pkt_open) begin
                commit_n = wr_n;
                open_n   = 1'b0;
            end
        end else if (mark) begin
            commit_n = wr_n;
            mark_n   = wr_n;
            open_n   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            commit_ptr <= '0;
            mark_ptr   <= '0;
            pkt_open   <= 1'b0;
            empty      <= 1'b1;
            full       <= 1'b0;
            level      <= '0;
        end else begin
            wr_ptr     <= wr_n;
            rd_ptr     <= rd_n;
            commit_ptr <= commit_n;
            mark_ptr   <= mark_n;
            pkt_open   <= open_n;
            empty      <= (commit_n == rd_n);
            full       <= ((wr_n - rd_n) == {1'b1, {FIFO_AW{1'b0}}});
            level      <= commit_n - rd_n;
        end
    end

    assign wr_addr = wr_ptr[FIFO_AW-1:0];
    assign rd_addr = rd_ptr[FIFO_AW-1:0];
endmodule

module sram_fifo_arb #(
    parameter int DW      = 16,
    parameter int AW      = 17,
    parameter int N_FIFO  = 2,
    parameter int FIFO_AW = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_FIFO-1:0]             wr_req,
    input  logic [N_FIFO*DW-1:0]          wr_data,
    output logic [N_FIFO-1:0]             wr_ack,
    input  logic [N_FIFO-1:0]             rd_req,
    output logic [N_FIFO*DW-1:0]          rd_data,
    output logic [N_FIFO-1:0]             rd_ack,
    input  logic [N_FIFO-1:0]             pkt_mark,
    input  logic [N_FIFO-1:0]             pkt_commit,
    input  logic [N_FIFO-1:0]             pkt_rollback,
    output logic [N_FIFO-1:0]             empty,
    output logic [N_FIFO-1:0]             full,
    output logic [N_FIFO*(FIFO_AW+1)-1:0] level,
    output logic [AW-1:0]                 mem_addr,
    inout  wire  [DW-1:0]                 mem_dq,
    output logic                          ce_n,
    output logic                          oe_n,
    output logic                          we_n,
    output logic                          lb_n,
    output logic                          ub_n
);
    localparam int NS  = 2 * N_FIFO;
    localparam int SW  = $clog2(NS);
    localparam int FIW = (N_FIFO > 1) ? $clog2(N_FIFO) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, CAPTURE, DONE} state_t;
    state_t state, state_n;

    logic [N_FIFO-1:0][DW-1:0]        wd, rd_q;
    logic [N_FIFO-1:0][FIFO_AW-1:0]   wr_addr_w, rd_addr_w;
    logic [N_FIFO-1:0][FIFO_AW:0]     level_w;
    logic [NS-1:0]                    elig;
    logic [2*NS-1:0]                  rot;
    logic [SW-1:0]                    rr_ptr, gidx, rr_next, cur_src;
    logic [SW:0]                      koff, gsum, nsum;
    logic [FIW-1:0]                   gnt_fifo, cur_fifo;
    logic [FIFO_AW-1:0]               gnt_ptr;
    logic [AW-1:0]                    gnt_addr;
    logic                             found, cur_wr, dq_oe;
    logic [DW-1:0]                    dq_out;

    assign wd       = wr_data;
    assign rd_data  = rd_q;
    assign level    = level_w;
    assign lb_n     = 1'b0;
    assign ub_n     = 1'b0;
    assign mem_dq   = dq_oe ? dq_out : 'z;
    assign cur_fifo = FIW'(cur_src >> 1);
    assign cur_wr   = ~cur_src[0];

    for (genvar i = 0; i < N_FIFO; i++) begin : g_ptr
        sram_fifo_arb_ptr #(.FIFO_AW(FIFO_AW)) u_ptr (
            .clk     (clk),
            .rst     (rst),
            .wr_done (wr_ack[i]),
            .rd_done (rd_ack[i]),
            .mark    (pkt_mark[i]),
            .commit  (pkt_commit[i]),
            .rollback(pkt_rollback[i]),
            .wr_addr (wr_addr_w[i]),
            .rd_addr (rd_addr_w[i]),
            .empty   (empty[i]),
            .full    (full[i]),
            .level   (level_w[i])
        );
    end

    // Rotate the eligible vector so the lowest set bit is the next in turn.
    always_comb begin
        for (int i = 0; i < N_FIFO; i++) begin
            elig[2*i]   = wr_req[i] & ~full[i];
            elig[2*i+1] = rd_req[i] & ~empty[i];
        end
        rot   = {elig, elig} >> rr_ptr;
        found = 1'b0;
        koff  = '0;
        for (int k = NS - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                koff  = (SW+1)'(k);
            end
        end
        gsum = {1'b0, rr_ptr} + koff;
        if (gsum >= (SW+1)'(NS)) gsum = gsum - (SW+1)'(NS);
        gidx = gsum[SW-1:0];
        nsum = {1'b0, gidx} + 1'b1;
        rr_next  = (nsum == (SW+1)'(NS)) ? '0 : nsum[SW-1:0];
        gnt_fifo = FIW'(gidx >> 1);
        gnt_ptr  = gidx[0] ? rd_addr_w[gnt_fifo] : wr_addr_w[gnt_fifo];
        gnt_addr = (AW'(gnt_fifo) << FIFO_AW) | AW'(gnt_ptr);
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (found) state_n = SETUP;
            SETUP:   state_n = STROBE;
            STROBE:  state_n = CAPTURE;
            CAPTURE: state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // SRAM pins are registered and set on the edge entering each phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            cur_src  <= '0;
            mem_addr <= '0;
            ce_n     <= 1'b1;
            oe_n     <= 1'b1;
            we_n     <= 1'b1;
            dq_oe    <= 1'b0;
            dq_out   <= '0;
            rd_q     <= '0;
            wr_ack   <= '0;
            rd_ack   <= '0;
        end else begin
            wr_ack <= '0;
            rd_ack <= '0;
            case (state)
                IDLE: if (found) begin
                    cur_src  <= gidx;
                    rr_ptr   <= rr_next;
                    mem_addr <= gnt_addr;
                    ce_n     <= 1'b0;
                    dq_oe    <= ~gidx[0];
                    dq_out   <= wd[gnt_fifo];
                end
                SETUP: begin
                    if (cur_wr) we_n <= 1'b0;
                    else        oe_n <= 1'b0;
                end
                STROBE: begin
                    // Read data is taken while oe_n is still low at this edge.
                    if (!cur_wr) rd_q[cur_fifo] <= mem_dq;
                    we_n <= 1'b1;
                    oe_n <= 1'b1;
                end
                CAPTURE: begin
                    if (cur_wr) wr_ack[cur_fifo] <= 1'b1;
                    else        rd_ack[cur_fifo] <= 1'b1;
                    ce_n  <= 1'b1;
                    dq_oe <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_fifo_arb.sv
// Directed bench for sram_fifo_arb with a small behavioural SRAM.
// Uses 16-word FIFOs so fill/wrap cases stay short.

module tb_sram_fifo_arb;
    localparam int DW = 16, AW = 5, NF = 2, FAW = 4;

    logic clk = 1'b0;
    logic rst;
    logic [NF-1:0] wr_req, rd_req, pkt_mark, pkt_commit, pkt_rollback;
    logic [NF-1:0] wr_ack, rd_ack, empty, full;
    logic [NF*DW-1:0] wr_data, rd_data;
    logic [NF*(FAW+1)-1:0] level;
    logic [AW-1:0] mem_addr;
    wire  [DW-1:0] mem_dq;
    logic ce_n, oe_n, we_n, lb_n, ub_n;
    logic [DW-1:0] sram [0:(1<<AW)-1];
    int n_vec = 0, n_err = 0;

    sram_fifo_arb #(.DW(DW), .AW(AW), .N_FIFO(NF), .FIFO_AW(FAW)) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_data(rd_data), .rd_ack(rd_ack),
        .pkt_mark(pkt_mark), .pkt_commit(pkt_commit), .pkt_rollback(pkt_rollback),
        .empty(empty), .full(full), .level(level),
        .mem_addr(mem_addr), .mem_dq(mem_dq),
        .ce_n(ce_n), .oe_n(oe_n), .we_n(we_n), .lb_n(lb_n), .ub_n(ub_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (!ce_n && !we_n) sram[mem_addr] <= mem_dq;
    assign mem_dq = (!ce_n && !oe_n) ? sram[mem_addr] : 'z;

    function automatic logic [FAW:0] lvl(input int f);
        return level[f*(FAW+1) +: FAW+1];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One full access; returns ack latency, first SRAM address seen, read data.
    task automatic access(input int f, input bit rd, input logic [DW-1:0] d,
                          output int lat, output logic [AW-1:0] addr, output logic [DW-1:0] q);
        bit seen;
        seen = 1'b0; lat = 0; addr = '0;
        if (rd) rd_req[f] = 1'b1;
        else begin wr_data[f*DW +: DW] = d; wr_req[f] = 1'b1; end
        while (!(rd ? rd_ack[f] : wr_ack[f]) && lat < 40) begin
            @(negedge clk); lat++;
            if (!ce_n && !seen) begin seen = 1'b1; addr = mem_addr; end
        end
        q = rd_data[f*DW +: DW];
        if (rd) rd_req[f] = 1'b0; else wr_req[f] = 1'b0;
        @(negedge clk);
    endtask

    task automatic pkt(input logic [NF-1:0] m, input logic [NF-1:0] c, input logic [NF-1:0] r);
        pkt_mark = m; pkt_commit = c; pkt_rollback = r;
        @(negedge clk);
        pkt_mark = '0; pkt_commit = '0; pkt_rollback = '0;
    endtask

    task automatic watch(input int n, output logic [NF-1:0] ws, output logic [NF-1:0] rs);
        ws = '0; rs = '0;
        repeat (n) begin
            @(negedge clk);
            ws |= wr_ack; rs |= rd_ack;
            wr_req &= ~wr_ack; rd_req &= ~rd_ack;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, src, n;
        int exp_ord[5];
        logic [AW-1:0] addr;
        logic [DW-1:0] q;
        logic [NF-1:0] ws, rs;
        exp_ord = '{0, 1, 2, 3, 0};

        rst = 1'b1; wr_req = '0; rd_req = '0; wr_data = '0;
        pkt_mark = '0; pkt_commit = '0; pkt_rollback = '0;
        repeat (2) @(negedge clk);
        chk("rst_empty", empty, 2'b11);
        chk("rst_full", full, 2'b00);
        chk("rst_level", level, 0);
        chk("rst_strobes", {ce_n, oe_n, we_n, lb_n, ub_n}, 5'b11100);
        chk("rst_addr", mem_addr, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_acks", {wr_ack, rd_ack}, 0);
        rst = 1'b0;
        @(negedge clk);

        // single write then read
        access(0, 0, 16'hA5A5, lat, addr, q);
        chk("w0_lat", lat, 4);
        chk("w0_addr", addr, 0);
        chk("w0_empty", empty[0], 0);
        chk("w0_level", lvl(0), 1);
        access(0, 1, 0, lat, addr, q);
        chk("r0_lat", lat, 4);
        chk("r0_data", q, 16'hA5A5);
        chk("r0_empty", empty[0], 1);

        // round-robin with all four sources
        rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
        wr_data = {16'h2222, 16'h1111};
        wr_req = 2'b11; rd_req = 2'b11;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            while (wr_ack == 0 && rd_ack == 0 && n < 20) begin @(negedge clk); n++; end
            src = wr_ack[0] ? 0 : rd_ack[0] ? 1 : wr_ack[1] ? 2 : rd_ack[1] ? 3 : 9;
            chk("rr_order", src, exp_ord[g]);
            if (src == 3) chk("rr_rd1_data", rd_data[31:16], 16'h2222);
            if (g == 4) begin wr_req = '0; rd_req = '0; end
            else begin wr_req &= ~wr_ack; rd_req &= ~rd_ack; end
            @(negedge clk);
            if (g < 4) begin wr_req = 2'b11; rd_req = 2'b11; end
        end

        // read of empty FIFO1 is never acked while FIFO0 write proceeds
        wr_data[15:0] = 16'h3333;
        wr_req = 2'b01; rd_req = 2'b10;
        watch(12, ws, rs);
        chk("skip_wr_ack", ws, 2'b01);
        chk("skip_rd_ack", rs, 2'b00);
        rd_req = '0;
        chk("skip_level0", lvl(0), 2);
        access(0, 1, 0, lat, addr, q);
        chk("fifo0_rd_a", q, 16'h1111);
        access(0, 1, 0, lat, addr, q);
        chk("fifo0_rd_b", q, 16'h3333);

        // fill FIFO1 (starts at pointer 1, wraps to region base)
        for (int k = 0; k < 16; k++) begin
            access(1, 0, 16'h0100 + DW'(k), lat, addr, q);
            if (k == 0)  chk("fill_first_addr", addr, 5'h11);
            if (k == 15) chk("fill_wrap_addr", addr, 5'h10);
        end
        chk("fill_full", full[1], 1);
        chk("fill_level", lvl(1), 16);
        wr_data[31:16] = 16'hBEEF; wr_req[1] = 1'b1;
        watch(10, ws, rs);
        chk("full_blocked", ws, 2'b00);
        access(1, 1, 0, lat, addr, q);
        chk("full_rd_data", q, 16'h0100);
        chk("full_clear", full[1], 0);
        access(1, 0, 16'hBEEF, lat, addr, q);
        chk("pend_wr_lat", lat, 4);
        chk("pend_wr_addr", addr, 5'h11);
        for (int k = 1; k <= 16; k++) begin
            access(1, 1, 0, lat, addr, q);
            chk("drain_data", q, (k < 16) ? 32'h0100 + 32'(k) : 32'hBEEF);
        end
        chk("drain_empty", empty[1], 1);

        // packet rollback, then packet commit, on FIFO0 (pointers at 3)
        pkt(2'b01, 2'b00, 2'b00);
        for (int k = 0; k < 3; k++) access(0, 0, 16'hC000 + DW'(k), lat, addr, q);
        chk("open_level", lvl(0), 0);
        chk("open_empty", empty[0], 1);
        rd_req[0] = 1'b1;
        watch(8, ws, rs);
        chk("open_rd_blocked", rs, 2'b00);
        pkt(2'b00, 2'b00, 2'b01);
        watch(8, ws, rs);
        chk("rb_rd_blocked", rs, 2'b00);
        chk("rb_level", lvl(0), 0);
        rd_req = '0;
        pkt(2'b01, 2'b00, 2'b00);
        access(0, 0, 16'hD000, lat, addr, q);
        chk("rb_wr_ptr_back", addr, 5'h03);
        access(0, 0, 16'hD001, lat, addr, q);
        access(0, 0, 16'hD002, lat, addr, q);
        chk("pre_commit_level", lvl(0), 0);
        pkt(2'b00, 2'b01, 2'b00);
        chk("commit_level", lvl(0), 3);
        for (int k = 0; k < 3; k++) begin
            access(0, 1, 0, lat, addr, q);
            chk("commit_rd_data", q, 32'hD000 + 32'(k));
        end

        // rollback in the same cycle as the last packet write's ack
        pkt(2'b01, 2'b00, 2'b00);
        access(0, 0, 16'hE001, lat, addr, q);
        access(0, 0, 16'hE002, lat, addr, q);
        wr_data[15:0] = 16'hE003; wr_req[0] = 1'b1; n = 0;
        while (!wr_ack[0] && n < 40) begin @(negedge clk); n++; end
        chk("rb_same_ack_lat", n, 4);
        pkt_rollback[0] = 1'b1; wr_req[0] = 1'b0;
        @(negedge clk);
        pkt_rollback = '0;
        chk("rb_same_level", lvl(0), 0);
        chk("rb_same_empty", empty[0], 1);
        access(0, 0, 16'h7777, lat, addr, q);
        chk("rb_same_addr", addr, 5'h06);
        chk("rb_same_level1", lvl(0), 1);
        access(0, 1, 0, lat, addr, q);
        chk("rb_same_rd", q, 16'h7777);

        // reset during STROBE
        wr_data[31:16] = 16'h5A5A; wr_req[1] = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("strobe_we_low", we_n, 0);
        rst = 1'b1;
        #1;
        chk("rst_we_high", we_n, 1);
        chk("rst_ce_high", ce_n, 1);
        wr_req = '0;
        @(negedge clk);
        rst = 1'b0;
        watch(8, ws, rs);
        chk("rst_no_ack", ws, 2'b00);
        chk("rst_empty_after", empty, 2'b11);
        chk("rst_level_after", level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
